// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch FSM encoding, reset PC and bubble instruction.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetchState_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {InstrD, PCPlus4D, ValidD}, enabled by ~StallD, with bubble load.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcPlus4In,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (en) begin
            if (bubble) begin
                InstrD   <= NOP_INSTR;
                PCPlus4D <= 32'd0;
                ValidD   <= 1'b0;
            end else begin
                InstrD   <= instrIn;
                PCPlus4D <= pcPlus4In;
                ValidD   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem req/ready handshake, one-entry skid buffer and redirect drain.
// Handshake: a fetch completes when ImemReqF & ImemReadyF; ImemAddrF (= PCF) is held while ImemReqF waits.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic        jump,
    input  logic [31:0] PCBranchD,
    output logic        ImemReqF,
    output logic [31:0] ImemAddrF,
    input  logic [31:0] ImemRdataF,
    input  logic        ImemReadyF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output fetchState_t dbgStateF
);

    fetchState_t state;
    logic [31:0] skid;
    logic [31:0] redirTgt;

    logic        stall;
    logic        redirect;
    logic        completion;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] ifWord;

    assign stall      = StallF | StallD;
    assign redirect   = (PCSrcD | jump) & ~StallD;
    assign completion = ImemReqF & ImemReadyF;
    assign target     = jump ? {PCPlus4D[31:28], InstrD[25:0], 2'b00} : PCBranchD;
    assign ImemAddrF  = PCF;
    assign dbgStateF  = state;

    // Only a completed fetch or a released skid entry reaches decode; everything else is a bubble.
    always_comb begin
        deliver = 1'b0;
        ifWord  = ImemRdataF;
        case (state)
            FETCH_RUN:  deliver = completion & ~redirect & ~stall;
            FETCH_HOLD: begin
                deliver = ~redirect & ~stall;
                ifWord  = skid;
            end
            default:    deliver = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH_RUN;
            PCF      <= RESET_PC;
            ImemReqF <= 1'b0;
            skid     <= 32'd0;
            redirTgt <= 32'd0;
        end else begin
            case (state)
                FETCH_RUN: begin
                    if (!ImemReqF) begin
                        // First cycle out of reset: nothing outstanding, so a redirect is immediate.
                        ImemReqF <= 1'b1;
                        if (redirect) PCF <= target;
                    end else if (redirect && completion) begin
                        PCF <= target;
                    end else if (redirect) begin
                        redirTgt <= target;
                        state    <= FETCH_DRAIN;
                    end else if (completion && !stall) begin
                        PCF <= pcPlus4(PCF);
                    end else if (completion) begin
                        skid     <= ImemRdataF;
                        ImemReqF <= 1'b0;
                        state    <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect) begin
                        PCF      <= target;
                        ImemReqF <= 1'b1;
                        state    <= FETCH_RUN;
                    end else if (!stall) begin
                        PCF      <= pcPlus4(PCF);
                        ImemReqF <= 1'b1;
                        state    <= FETCH_RUN;
                    end
                end
                FETCH_DRAIN: begin
                    // The old request must finish before the new address may be presented.
                    if (redirect) redirTgt <= target;
                    if (completion) begin
                        PCF   <= redirect ? target : redirTgt;
                        state <= FETCH_RUN;
                    end
                end
                default: begin
                    state    <= FETCH_RUN;
                    ImemReqF <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .en        (~StallD),
        .bubble    (~deliver),
        .instrIn   (ifWord),
        .pcPlus4In (pcPlus4(PCF)),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

endmodule
